// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with the architectural HI/LO
// registers of a MIPS-style pipeline.
//
// The arithmetic result is computed combinationally in the Start cycle and
// parked in TmpHI/TmpLO. A down-counter then models the latency of the unit:
// Busy stays high for MULT_CYC or DIV_CYC cycles. HI/LO are updated on the
// edge that ends the busy period, so the new values are visible in the cycle
// Busy falls. mthi/mtlo write HI/LO directly when the unit is idle.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset
//   Start    in   1   E-stage instruction is mult/multu/div/divu
//   MDOp     in   2   00 mult, 01 multu, 10 div, 11 divu
//   MTHI     in   1   E-stage instruction is mthi
//   MTLO     in   1   E-stage instruction is mtlo
//   A        in  32   rs operand (forwarded)
//   B        in  32   rt operand (forwarded)
//   UseMD    in   1   D-stage instruction touches the multiply/divide unit
//   Busy     out  1   operation in progress
//   MDStall  out  1   combinational stall request to the hazard logic
//   HI       out 32   architectural HI register
//   LO       out 32   architectural LO register
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        UseMD,
    output logic        Busy,
    output logic        MDStall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_tmp_hi;
    logic [31:0] r_tmp_lo;
    logic        r_skip_wb;   // div by zero: run the full latency, keep HI/LO

    logic               w_b_zero;
    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [63:0] w_sb_div;
    logic        [31:0] w_ub_div;
    logic signed [63:0] w_mul_s;
    logic        [63:0] w_mul_u;
    logic signed [63:0] w_quo_s;
    logic signed [63:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;
    logic        [3:0]  w_load;
    logic               w_div_op;

    // Operands are widened to 64 bits so that 0x80000000 / -1 yields +2^31,
    // whose low word is 0x80000000 with a zero remainder, instead of
    // overflowing a 32-bit signed divide.
    assign w_b_zero = (B == 32'd0);
    assign w_sa     = {{32{A[31]}}, A};
    assign w_sb     = {{32{B[31]}}, B};
    // A zero divisor is replaced by one only to keep the divider defined;
    // that result is never written to HI/LO.
    assign w_sb_div = w_b_zero ? 64'sd1 : w_sb;
    assign w_ub_div = w_b_zero ? 32'd1  : B;

    assign w_mul_s  = w_sa * w_sb;
    assign w_mul_u  = {32'd0, A} * {32'd0, B};
    assign w_quo_s  = w_sa / w_sb_div;
    assign w_rem_s  = w_sa % w_sb_div;   // remainder carries the sign of A
    assign w_quo_u  = A / w_ub_div;
    assign w_rem_u  = A % w_ub_div;
    assign w_div_op = MDOp[1];

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        unique case (MDOp)
            OP_MULT: begin
                w_res_hi = w_mul_s[63:32];
                w_res_lo = w_mul_s[31:0];
            end
            OP_MULTU: begin
                w_res_hi = w_mul_u[63:32];
                w_res_lo = w_mul_u[31:0];
            end
            OP_DIV: begin
                w_res_hi = w_rem_s[31:0];
                w_res_lo = w_quo_s[31:0];
            end
            OP_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
            end
            default: ;
        endcase
    end

    assign w_load = w_div_op ? DIV_LOAD : MULT_LOAD;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_tmp_hi  <= 32'd0;
            r_tmp_lo  <= 32'd0;
            r_skip_wb <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        // Start wins over a simultaneous mthi/mtlo.
                        r_tmp_hi  <= w_res_hi;
                        r_tmp_lo  <= w_res_lo;
                        r_skip_wb <= w_div_op & w_b_zero;
                        r_cnt     <= w_load;
                        r_state   <= RUN;
                    end else begin
                        if (MTHI) r_hi <= A;
                        if (MTLO) r_lo <= A;
                    end
                end
                RUN: begin
                    // Start and mthi/mtlo are ignored while running.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (!r_skip_wb) begin
                            r_hi <= r_tmp_hi;
                            r_lo <= r_tmp_lo;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Busy    = (r_state == RUN);
    assign MDStall = UseMD & (Start | Busy);
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl (default latency
// parameters: 5 cycles for multiply, 10 for divide). Inputs change 1 ns after
// a rising edge; outputs are sampled 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  MDOp;
    logic        MTHI;
    logic        MTLO;
    logic [31:0] A;
    logic [31:0] B;
    logic        UseMD;
    logic        Busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    mdu_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .MTHI    (MTHI),
        .MTLO    (MTLO),
        .A       (A),
        .B       (B),
        .UseMD   (UseMD),
        .Busy    (Busy),
        .MDStall (MDStall),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and leave 1 ns of settling time.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a Start for one cycle, then drop Start and the operands' role.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        #1;
        check("start_cycle_busy", {31'd0, Busy}, 32'd0);
        tick();
        Start = 1'b0;
        #1;
    endtask

    // Expect Busy for exactly n cycles with HI/LO frozen at their old values,
    // then advance past the completion edge.
    task automatic expect_busy(input string tag, input int n,
                               input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            check({tag, "_hi_hold"}, HI, old_hi);
            check({tag, "_lo_hold"}, LO, old_lo);
            tick();
            #1;
        end
        check({tag, "_busy_fall"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 2'b00;
        MTHI  = 1'b0;
        MTLO  = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        UseMD = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_stall", {31'd0, MDStall}, 32'd0);
        reset = 1'b0;
        tick();

        // mult -2 * 3 with UseMD held: stall in Start cycle and all busy cycles.
        UseMD = 1'b1;
        Start = 1'b1;
        MDOp  = 2'b00;
        A     = 32'hFFFF_FFFE;
        B     = 32'd3;
        #1;
        check("mult_stall_start", {31'd0, MDStall}, 32'd1);
        tick();
        Start = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("mult_busy", {31'd0, Busy}, 32'd1);
            check("mult_stall_busy", {31'd0, MDStall}, 32'd1);
            check("mult_hi_hold", HI, 32'd0);
            tick();
            #1;
        end
        check("mult_busy_fall", {31'd0, Busy}, 32'd0);
        check("mult_stall_end", {31'd0, MDStall}, 32'd0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);
        UseMD = 1'b0;

        // multu max*max, with mthi/mtlo and a stray Start issued while running.
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        MTHI  = 1'b1;
        MTLO  = 1'b1;
        Start = 1'b1;
        MDOp  = 2'b10;
        A     = 32'hDEAD_BEEF;
        B     = 32'd7;
        #1;
        expect_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        MTHI  = 1'b0;
        MTLO  = 1'b0;
        Start = 1'b0;
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        // div -7 / 2: quotient -3, remainder -1.
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        expect_busy("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // Signed overflow case, with mthi in the Start cycle (Start wins).
        MTHI = 1'b1;
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        MTHI = 1'b0;
        expect_busy("div_ovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0000_0000);

        // divu 100 / 7: quotient 14, remainder 2.
        start_op(2'b11, 32'd100, 32'd7);
        expect_busy("divu", 10, 32'h0000_0000, 32'h8000_0000);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // mthi 0x11, mtlo 0x22, then divu by zero leaves them intact.
        MTHI = 1'b1;
        A    = 32'h11;
        tick();
        MTHI = 1'b0;
        #1;
        check("mthi_hi", HI, 32'h11);
        check("mthi_lo_keep", LO, 32'd14);
        MTLO = 1'b1;
        A    = 32'h22;
        tick();
        MTLO = 1'b0;
        #1;
        check("mtlo_lo", LO, 32'h22);
        check("mtlo_hi_keep", HI, 32'h11);
        start_op(2'b11, 32'd100, 32'd0);
        expect_busy("divu0", 10, 32'h11, 32'h22);
        check("divu0_hi", HI, 32'h11);
        check("divu0_lo", LO, 32'h22);

        // Both mthi and mtlo in one cycle.
        MTHI = 1'b1;
        MTLO = 1'b1;
        A    = 32'h55;
        tick();
        MTHI = 1'b0;
        MTLO = 1'b0;
        #1;
        check("mtboth_hi", HI, 32'h55);
        check("mtboth_lo", LO, 32'h55);

        // Reset on the 3rd busy cycle of div 9 / 3 aborts with no update.
        start_op(2'b10, 32'd9, 32'd3);
        check("abort_busy1", {31'd0, Busy}, 32'd1);
        tick();
        check("abort_busy2", {31'd0, Busy}, 32'd1);
        tick();
        check("abort_busy3", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_update_hi", HI, 32'd0);
            check("abort_no_update_lo", LO, 32'd0);
            check("abort_idle", {31'd0, Busy}, 32'd0);
        end

        // Start together with reset is ignored.
        reset = 1'b1;
        Start = 1'b1;
        MDOp  = 2'b01;
        A     = 32'd6;
        B     = 32'd7;
        tick();
        reset = 1'b0;
        Start = 1'b0;
        #1;
        check("rst_start_busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("rst_start_lo", LO, 32'd0);
        check("rst_start_hi", HI, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
